// File: rtl/bias_sram_ctrl.sv
// Bias SRAM controller: streams bias words into a single-port SRAM (load)
// and streams a window of them back out through a 2-entry FIFO (fetch).
module bias_sram_ctrl #(
    parameter int AW    = 9,
    parameter int DW    = 32,
    parameter int DEPTH = 384
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic [AW-1:0] load_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          fetch_start,
    input  logic [AW-1:0] fetch_base,
    input  logic [AW-1:0] fetch_len,
    output logic          bias_valid,
    output logic [DW-1:0] bias_data,
    input  logic          bias_ready,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          sram_cs,
    output logic          sram_oe,
    output logic          sram_web,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    typedef enum logic [1:0] {IDLE, LOAD, FETCH, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] ld_left;
    logic [AW-1:0] rptr;
    logic [AW-1:0] rd_left;
    logic [AW-1:0] out_left;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          arm;
    logic          inflight;
    logic          done_q;
    logic          err_q;

    logic [DW-1:0] fifo_head;
    logic [DW-1:0] fifo_tail;
    logic [1:0]    occ;

    logic          beat;
    logic          issue;
    logic          pop;
    logic          push;
    logic [2:0]    outstanding;
    logic          load_bad;
    logic          fetch_bad;

    // Handshake decode, read credit and command legality checks.
    // The word leaving the FIFO this cycle frees its slot, so a read may be
    // issued alongside a pop; this keeps one word per cycle with only two
    // storage slots (FIFO + in-flight never exceeds two after the edge).
    always_comb begin
        beat        = (state == LOAD) && ld_valid;
        pop         = (occ != 2'd0) && bias_ready;
        push        = inflight;
        outstanding = 3'(occ) + 3'(inflight) - 3'(pop);
        issue       = (state == FETCH) && !arm && (rd_left != '0) && (outstanding < 3'd2);
        load_bad    = (load_len == '0) || ({1'b0, load_len} > DEPTH_W);
        fetch_bad   = (fetch_len == '0) ||
                      (({1'b0, fetch_base} + {1'b0, fetch_len}) > DEPTH_W);
    end

    // Control FSM, address/length counters and registered status pulses.
    // The first FETCH cycle is a setup cycle (arm), so the first read goes
    // out one cycle after acceptance and the first word appears three
    // cycles after the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wptr     <= '0;
            ld_left  <= '0;
            rptr     <= '0;
            rd_left  <= '0;
            out_left <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            arm      <= 1'b0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            inflight <= issue;
            if (beat) begin
                addr_q  <= wptr;
                wdata_q <= ld_data;
            end else if (issue) begin
                addr_q <= rptr;
            end
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (load_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            wptr    <= '0;
                            ld_left <= load_len;
                        end
                    end else if (fetch_start) begin
                        if (fetch_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            rptr     <= fetch_base;
                            rd_left  <= fetch_len;
                            out_left <= fetch_len;
                            arm      <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        wptr    <= wptr + AW'(1);
                        ld_left <= ld_left - AW'(1);
                        if (ld_left == AW'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    arm <= 1'b0;
                    if (issue) begin
                        rptr    <= rptr + AW'(1);
                        rd_left <= rd_left - AW'(1);
                    end
                    if (pop) begin
                        out_left <= out_left - AW'(1);
                        if (out_left == AW'(1)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-entry output FIFO; read data is captured the cycle after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_head <= '0;
            fifo_tail <= '0;
            occ       <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        fifo_head <= sram_rdata;
                    end else begin
                        fifo_tail <= sram_rdata;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    fifo_head <= fifo_tail;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        fifo_head <= sram_rdata;
                    end else begin
                        fifo_head <= fifo_tail;
                        fifo_tail <= sram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ld_ready   = (state == LOAD);
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign bias_valid = (occ != 2'd0);
    assign bias_data  = fifo_head;

    // SRAM strobes: writes follow ld_data in the beat cycle; address and
    // write data hold their last driven value between accesses.
    always_comb begin
        sram_cs    = beat || issue;
        sram_oe    = issue;
        sram_web   = !beat;
        sram_addr  = beat ? wptr : (issue ? rptr : addr_q);
        sram_wdata = beat ? ld_data : wdata_q;
    end

endmodule

// File: tb/tb_bias_sram_ctrl.sv
// Directed self-checking bench for bias_sram_ctrl with a behavioural SRAM.
module tb_bias_sram_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 384;

    logic          clk;
    logic          rst;
    logic          load_start;
    logic [AW-1:0] load_len;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          fetch_start;
    logic [AW-1:0] fetch_base;
    logic [AW-1:0] fetch_len;
    logic          bias_valid;
    logic [DW-1:0] bias_data;
    logic          bias_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic          sram_cs;
    logic          sram_oe;
    logic          sram_web;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int n_checks;
    int n_errors;

    logic [DW-1:0] mem     [0:511];
    logic [DW-1:0] ref_mem [0:511];

    bias_sram_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .fetch_start(fetch_start), .fetch_base(fetch_base), .fetch_len(fetch_len),
        .bias_valid(bias_valid), .bias_data(bias_data), .bias_ready(bias_ready),
        .busy(busy), .done(done), .err(err),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM: read data valid the cycle after the request.
    always @(posedge clk) begin
        if (sram_cs) begin
            if (!sram_web) mem[sram_addr] <= sram_wdata;
            else if (sram_oe) sram_rdata <= mem[sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int unsigned len, input logic [31:0] seed, input logic both);
        load_start  = 1'b1;
        load_len    = AW'(len);
        fetch_start = both;
        fetch_base  = '0;
        fetch_len   = AW'(1);
        ld_valid    = 1'b0;
        tick();
        load_start = 1'b0;
        check("load_busy_ready", {30'd0, busy, ld_ready}, 32'd3);
        #1;
        check("load_gap_cs", {31'd0, sram_cs}, 32'd0);
        tick();
        for (int unsigned i = 0; i < len; i++) begin
            ld_valid = 1'b1;
            ld_data  = seed + i;
            #1;
            check("load_ctl", {27'd0, sram_cs, sram_web, sram_oe, ld_ready, done}, 32'b10010);
            check("load_addr", {23'd0, sram_addr}, i);
            check("load_wdata", sram_wdata, seed + i);
            ref_mem[i] = seed + i;
            tick();
        end
        ld_valid    = 1'b0;
        ld_data     = '0;
        fetch_start = 1'b0;
        #1;
        check("load_done", {29'd0, done, busy, sram_cs}, 32'b110);
        check("load_hold_addr", {23'd0, sram_addr}, len - 1);
        check("load_hold_wdata", sram_wdata, seed + len - 1);
        tick();
        check("load_idle", {28'd0, done, busy, bias_valid, sram_oe}, 32'd0);
    endtask

    task automatic run_fetch(input int unsigned base, input int unsigned len, input logic [5:0] pat);
        int unsigned issued, consumed, maxo, dones, cyc, first_v, last_pop;
        logic order_ok;
        issued = 0; consumed = 0; maxo = 0; dones = 0; cyc = 0;
        first_v = 999; last_pop = 0; order_ok = 1'b1;
        fetch_start = 1'b1;
        fetch_base  = AW'(base);
        fetch_len   = AW'(len);
        tick();
        fetch_start = 1'b0;
        check("fetch_busy", {31'd0, busy}, 32'd1);
        while (consumed < len && cyc < len * 4 + 20) begin
            bias_ready = pat[cyc % 6];
            #1;
            if (bias_valid && first_v == 999) first_v = cyc;
            if (sram_cs && sram_oe && sram_web) begin
                if (sram_addr != AW'(base + issued)) order_ok = 1'b0;
                issued++;
            end
            if (bias_valid && bias_ready) begin
                check("fetch_data", bias_data, ref_mem[base + consumed]);
                consumed++;
                last_pop = cyc;
            end
            if (done) dones++;
            if (issued - consumed > maxo) maxo = issued - consumed;
            tick();
            cyc++;
        end
        check("fetch_consumed", consumed, len);
        check("fetch_issued", issued, len);
        check("fetch_order", {31'd0, order_ok}, 32'd1);
        check("fetch_outstanding_gt2", {31'd0, maxo > 2}, 32'd0);
        check("fetch_early_done", dones, 0);
        if (pat == 6'h3F) begin
            check("fetch_first_latency", first_v, 3);
            check("fetch_sustain", last_pop, first_v + len - 1);
        end
        check("fetch_done", {30'd0, done, busy}, 32'b11);
        tick();
        check("fetch_idle", {29'd0, done, busy, bias_valid}, 32'd0);
        bias_ready = 1'b0;
    endtask

    task automatic err_cmd(input logic is_load, input int unsigned base, input int unsigned len);
        load_start  = is_load;
        fetch_start = !is_load;
        load_len    = AW'(len);
        fetch_base  = AW'(base);
        fetch_len   = AW'(len);
        tick();
        load_start  = 1'b0;
        fetch_start = 1'b0;
        check("err_pulse", {28'd0, err, busy, sram_cs, ld_ready}, 32'b1000);
        tick();
        check("err_clear", {28'd0, err, busy, sram_cs, bias_valid}, 32'd0);
    endtask

    initial begin
        logic saw_done;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        load_start = 1'b0; load_len = '0; ld_valid = 1'b0; ld_data = '0;
        fetch_start = 1'b0; fetch_base = '0; fetch_len = '0; bias_ready = 1'b0;
        tick();
        tick();
        check("rst_flags", {24'd0, bias_valid, ld_ready, busy, done, err, sram_cs, sram_oe, sram_web},
              32'b00000001);
        check("rst_bias_data", bias_data, 32'd0);
        check("rst_addr", {23'd0, sram_addr}, 32'd0);
        check("rst_wdata", sram_wdata, 32'd0);
        rst = 1'b0;
        tick();

        // load with a simultaneous fetch_start that must be dropped
        do_load(4, 32'hA0, 1'b1);

        run_fetch(1, 3, 6'h3F);
        run_fetch(1, 3, 6'b101001);

        err_cmd(1'b0, 0, 0);
        err_cmd(1'b0, 380, 5);
        err_cmd(1'b0, 1, 384);
        err_cmd(1'b1, 0, 0);
        err_cmd(1'b1, 0, 385);

        // reset on the second delivered word of a 5-word fetch
        bias_ready  = 1'b1;
        fetch_start = 1'b1;
        fetch_base  = '0;
        fetch_len   = AW'(5);
        tick();
        fetch_start = 1'b0;
        tick(); tick(); tick();
        check("rstmid_first_word", {31'd0, bias_valid}, 32'd1);
        tick();
        check("rstmid_second_word", bias_data, ref_mem[1]);
        rst = 1'b1;
        tick();
        check("rstmid_abort", {28'd0, bias_valid, busy, sram_cs, done}, 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("rstmid_no_done", {31'd0, saw_done}, 32'd0);
        bias_ready = 1'b0;

        run_fetch(1, 3, 6'h3F);

        do_load(384, 32'h0BA5_0000, 1'b0);
        run_fetch(0, 384, 6'h3F);
        run_fetch(380, 4, 6'b101001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
